// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for the two-requester AXI3 read arbiter: requester request/response
// channels plus the shared AR/R master channels.
interface axi_rd_arbiter_if #(
    parameter int unsigned ADDR_WID = 32
);
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;

    // Instruction-side requester
    logic                inst_req_valid;
    logic                inst_req_ready;
    logic [ADDR_WID-1:0] inst_req_addr;
    logic [LEN_W-1:0]    inst_req_len;
    logic                inst_resp_valid;
    logic                inst_resp_ready;
    logic [DATA_W-1:0]   inst_resp_data;
    logic                inst_resp_last;

    // Data-side requester
    logic                data_req_valid;
    logic                data_req_ready;
    logic [ADDR_WID-1:0] data_req_addr;
    logic [LEN_W-1:0]    data_req_len;
    logic                data_resp_valid;
    logic                data_resp_ready;
    logic [DATA_W-1:0]   data_resp_data;
    logic                data_resp_last;

    // AXI AR channel
    logic [ID_W-1:0]     arid;
    logic [ADDR_WID-1:0] araddr;
    logic [LEN_W-1:0]    arlen;
    logic                arvalid;
    logic                arready;

    // AXI R channel
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    // Arbiter side
    modport master (
        input  inst_req_valid, inst_req_addr, inst_req_len, inst_resp_ready,
        output inst_req_ready, inst_resp_valid, inst_resp_data, inst_resp_last,
        input  data_req_valid, data_req_addr, data_req_len, data_resp_ready,
        output data_req_ready, data_resp_valid, data_resp_data, data_resp_last,
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    // Requesters and AXI slave side
    modport slave (
        output inst_req_valid, inst_req_addr, inst_req_len, inst_resp_ready,
        input  inst_req_ready, inst_resp_valid, inst_resp_data, inst_resp_last,
        output data_req_valid, data_req_addr, data_req_len, data_resp_ready,
        input  data_req_ready, data_resp_valid, data_resp_data, data_resp_last,
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester (inst/data) AXI3 read arbiter with per-requester outstanding-burst limits.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-first priority.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_WID        = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic              clk,
    input logic              resetn,
    axi_rd_arbiter_if.master bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned ID_W  = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [ADDR_WID-1:0] araddr_q;
    logic [ADDR_WID-1:0] araddr_nxt;
    logic [LEN_W-1:0]    arlen_q;
    logic [LEN_W-1:0]    arlen_nxt;
    logic [ID_W-1:0]     arid_q;
    logic [ID_W-1:0]     arid_nxt;

    logic [CNT_W-1:0]    inst_cnt;
    logic [CNT_W-1:0]    data_cnt;

    logic inst_elig_c;
    logic data_elig_c;
    logic sel_c;
    logic grant_c;
    logic inst_grant_c;
    logic data_grant_c;

    logic rsel_c;
    logic rready_c;
    logic inst_done_c;
    logic data_done_c;
    logic unused_rid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
`endif

    // Eligibility and requester selection
    always_comb begin
        inst_elig_c = bus.inst_req_valid && (inst_cnt < CNT_W'(MAX_OUTSTANDING));
        data_elig_c = bus.data_req_valid && (data_cnt < CNT_W'(MAX_OUTSTANDING));
        sel_c       = SEL_DATA;
        if (inst_elig_c && data_elig_c) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel_c = ~last_grant;
`else
            sel_c = SEL_DATA;
`endif
        end else if (inst_elig_c) begin
            sel_c = SEL_INST;
        end
    end

    // Next-state and AR payload capture
    always_comb begin
        state_nxt  = state;
        araddr_nxt = araddr_q;
        arlen_nxt  = arlen_q;
        arid_nxt   = arid_q;
        grant_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (resetn && (inst_elig_c || data_elig_c)) begin
                    grant_c    = 1'b1;
                    state_nxt  = ST_ISSUE;
                    araddr_nxt = (sel_c == SEL_DATA) ? bus.data_req_addr : bus.inst_req_addr;
                    arlen_nxt  = (sel_c == SEL_DATA) ? bus.data_req_len  : bus.inst_req_len;
                    arid_nxt   = {3'b000, sel_c};
                end
            end
            ST_ISSUE: begin
                if (bus.arready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            arid_q   <= '0;
        end else begin
            state    <= state_nxt;
            araddr_q <= araddr_nxt;
            arlen_q  <= arlen_nxt;
            arid_q   <= arid_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to data so the first contested grant goes to inst
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= SEL_DATA;
        end else if (grant_c) begin
            last_grant <= sel_c;
        end
    end
`endif

    assign inst_grant_c = grant_c && (sel_c == SEL_INST);
    assign data_grant_c = grant_c && (sel_c == SEL_DATA);

    assign bus.inst_req_ready = inst_grant_c;
    assign bus.data_req_ready = data_grant_c;

    assign bus.arvalid = (state == ST_ISSUE);
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arid    = arid_q;

    // R channel steering on rid[0]; upper id bits carry no routing meaning
    assign rsel_c     = bus.rid[0];
    assign unused_rid = ^bus.rid[ID_W-1:1];
    assign rready_c   = rsel_c ? bus.data_resp_ready : bus.inst_resp_ready;

    assign bus.rready          = rready_c;
    assign bus.inst_resp_valid = bus.rvalid && !rsel_c;
    assign bus.data_resp_valid = bus.rvalid && rsel_c;
    assign bus.inst_resp_data  = bus.rdata;
    assign bus.data_resp_data  = bus.rdata;
    assign bus.inst_resp_last  = bus.rlast;
    assign bus.data_resp_last  = bus.rlast;

    assign inst_done_c = bus.rvalid && rready_c && bus.rlast && !rsel_c;
    assign data_done_c = bus.rvalid && rready_c && bus.rlast && rsel_c;

    // Outstanding bursts: simultaneous issue and completion cancel; never drops below zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_cnt <= '0;
        end else if (inst_grant_c && !inst_done_c) begin
            inst_cnt <= inst_cnt + CNT_W'(1);
        end else if (!inst_grant_c && inst_done_c && (inst_cnt != '0)) begin
            inst_cnt <= inst_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_cnt <= '0;
        end else if (data_grant_c && !data_done_c) begin
            data_cnt <= data_cnt + CNT_W'(1);
        end else if (!data_grant_c && data_done_c && (data_cnt != '0)) begin
            data_cnt <= data_cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed scenarios followed by randomized traffic.
module tb_axi_rd_arbiter;
    localparam int unsigned AW   = 32;
    localparam int          MAXO = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ADDR_WID(AW)) bus ();

    axi_rd_arbiter #(.ADDR_WID(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [3:0]    id;
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } ar_t;

    typedef struct packed {
        logic        side;
        logic [31:0] data;
        logic        last;
    } r_t;

    ar_t ar_q[$];
    r_t  r_q[$];
    int  pend_i[$];
    int  pend_d[$];

    int checks = 0;
    int errors = 0;

    // Reference state: AR slot busy, outstanding bursts, last winner (1 = data)
    bit m_busy = 1'b0;
    bit m_last = 1'b1;
    int m_cnt_i = 0;
    int m_cnt_d = 0;

    bit cur_active = 1'b0;
    bit cur_side   = 1'b0;
    int cur_len    = 0;
    int cur_beat   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts grants, AR occupancy and R steering from the rules
    always @(negedge clk) begin : model
        bit ei, ed, gi, gd, rs, er, di, dd;
        rs = bus.rid[0];
        er = rs ? bus.data_resp_ready : bus.inst_resp_ready;
        chk("rready", bus.rready, er);
        chk("inst_resp_valid", bus.inst_resp_valid, bus.rvalid && !rs);
        chk("data_resp_valid", bus.data_resp_valid, bus.rvalid && rs);
        if (!resetn) begin
            m_busy = 1'b0; m_last = 1'b1; m_cnt_i = 0; m_cnt_d = 0;
            ar_q.delete(); pend_i.delete(); pend_d.delete();
            chk("rst_inst_req_ready", bus.inst_req_ready, 1'b0);
            chk("rst_data_req_ready", bus.data_req_ready, 1'b0);
            chk("rst_arvalid", bus.arvalid, 1'b0);
        end else begin
            gi = 1'b0; gd = 1'b0;
            if (!m_busy) begin
                ei = bus.inst_req_valid && (m_cnt_i < MAXO);
                ed = bus.data_req_valid && (m_cnt_d < MAXO);
                if (ei && ed) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (m_last) gi = 1'b1; else gd = 1'b1;
`else
                    gd = 1'b1;
`endif
                end else begin
                    gi = ei; gd = ed;
                end
            end
            chk("arvalid", bus.arvalid, m_busy);
            chk("inst_req_ready", bus.inst_req_ready, gi);
            chk("data_req_ready", bus.data_req_ready, gd);
            di = bus.rvalid && er && bus.rlast && !rs;
            dd = bus.rvalid && er && bus.rlast && rs;
            if (m_busy && bus.arready) m_busy = 1'b0;
            if (gi) begin
                ar_q.push_back({4'd0, bus.inst_req_addr, bus.inst_req_len});
                pend_i.push_back(int'(bus.inst_req_len));
            end
            if (gd) begin
                ar_q.push_back({4'd1, bus.data_req_addr, bus.data_req_len});
                pend_d.push_back(int'(bus.data_req_len));
            end
            if (gi || gd) begin
                m_busy = 1'b1;
                m_last = gd;
            end
            m_cnt_i = m_cnt_i + int'(gi) - int'(di);
            m_cnt_d = m_cnt_d + int'(gd) - int'(dd);
            if (m_cnt_i < 0) m_cnt_i = 0;
            if (m_cnt_d < 0) m_cnt_d = 0;
        end
    end

    // Monitor: pops expected AR and R beats when the DUT completes a handshake
    always @(negedge clk) begin : monitor
        ar_t e;
        r_t  re;
        if (bus.arvalid && bus.arready) begin
            if (ar_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_unexpected: got arid 0x%0h araddr 0x%0h expected none at %0t",
                         bus.arid, bus.araddr, $time);
            end else begin
                e = ar_q.pop_front();
                chk("arid", bus.arid, e.id);
                chk("araddr", bus.araddr, e.addr);
                chk("arlen", bus.arlen, e.len);
            end
        end
        if ((bus.inst_resp_valid && bus.inst_resp_ready) ||
            (bus.data_resp_valid && bus.data_resp_ready)) begin
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got beat 0x%0h expected none at %0t", bus.rdata, $time);
            end else begin
                re = r_q.pop_front();
                chk("r_side", bus.data_resp_valid, re.side);
                chk("r_data", re.side ? bus.data_resp_data : bus.inst_resp_data, re.data);
                chk("r_last", re.side ? bus.data_resp_last : bus.inst_resp_last, re.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req_valid = 1'b0; bus.inst_req_addr = '0; bus.inst_req_len = '0;
        bus.data_req_valid = 1'b0; bus.data_req_addr = '0; bus.data_req_len = '0;
        bus.inst_resp_ready = 1'b0; bus.data_resp_ready = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rlast = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        r_q.delete();
        cur_active = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic drive_beat(input bit side, input logic [31:0] d, input bit last);
        bus.rvalid = 1'b1;
        bus.rid    = {3'($urandom), side};
        bus.rdata  = d;
        bus.rlast  = last;
        r_q.push_back({side, d, last});
    endtask

    initial begin : stim
        int order[$];
        int exp_order[6];
        bit exp_i, exp_d;
        bit rdy;
        resetn = 1'b0;
        idle_inputs();

        // Single inst burst: ready in grant cycle, AR one cycle later
        do_reset();
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h1000; bus.inst_req_len = 4'd3;
        bus.arready = 1'b1;
        #1;
        chk("t032_inst_ready", bus.inst_req_ready, 1'b1);
        tick();
        bus.inst_req_valid = 1'b0;
        #1;
        chk("t032_arvalid", bus.arvalid, 1'b1);
        chk("t032_arid", bus.arid, 4'd0);
        chk("t032_araddr", bus.araddr, 32'h1000);
        chk("t032_arlen", bus.arlen, 4'd3);
        tick();

        // Grant order with both requesters always valid
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{1, 1, 1, 1, 0, 0};
`endif
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h100;
        bus.data_req_valid = 1'b1; bus.data_req_addr = 32'h200;
        bus.arready = 1'b1;
        order.delete();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.inst_req_ready) order.push_back(0);
            if (bus.data_req_ready) order.push_back(1);
            tick();
        end
        chk("t033_grant_count", order.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t033_grant%0d", k), (k < order.size()) ? order[k] : 9, exp_order[k]);

        // AR stall: payload stable, no grants until back in IDLE
        do_reset();
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'hA0; bus.inst_req_len = 4'd2;
        #1;
        chk("t034_grant", bus.inst_req_ready, 1'b1);
        tick();
        bus.inst_req_addr = 32'hBEEF0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t034_araddr_stable", bus.araddr, 32'hA0);
            chk("t034_arid_stable", bus.arid, 4'd0);
            chk("t034_no_ready", bus.inst_req_ready, 1'b0);
            tick();
        end
        bus.arready = 1'b1;
        tick();
        #1;
        chk("t034_resume", bus.inst_req_ready, 1'b1);
        tick();

        // Data side saturates at the outstanding limit, one completion frees a slot
        do_reset();
        bus.data_req_valid = 1'b1; bus.data_req_addr = 32'h4000; bus.arready = 1'b1;
        repeat (10) tick();
        #1;
        chk("t035_full", bus.data_req_ready, 1'b0);
        bus.data_resp_ready = 1'b1;
        drive_beat(1'b1, 32'h0123_4567, 1'b1);
        #1;
        chk("t035_same_cycle", bus.data_req_ready, 1'b0);
        tick();
        bus.rvalid = 1'b0;
        #1;
        chk("t035_regrant", bus.data_req_ready, 1'b1);
        tick();

        // Completion with zero outstanding must not underflow
        do_reset();
        bus.data_resp_ready = 1'b1;
        drive_beat(1'b1, 32'h5555_AAAA, 1'b1);
        tick();
        bus.rvalid = 1'b0;
        bus.data_req_valid = 1'b1; bus.arready = 1'b1;
        #1;
        chk("t023_no_underflow", bus.data_req_ready, 1'b1);
        repeat (10) tick();

        // R steering toward a stalled inst requester
        do_reset();
        bus.inst_resp_ready = 1'b0; bus.data_resp_ready = 1'b1;
        drive_beat(1'b0, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("t036_inst_valid", bus.inst_resp_valid, 1'b1);
        chk("t036_data_valid", bus.data_resp_valid, 1'b0);
        chk("t036_rready", bus.rready, 1'b0);
        chk("t036_data", bus.inst_resp_data, 32'hDEAD_BEEF);
        tick();
        bus.inst_resp_ready = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        tick();

        // Asynchronous reset while an AR is pending
        do_reset();
        bus.arready = 1'b1;
        bus.data_req_valid = 1'b1; bus.data_req_addr = 32'h7000;
        repeat (5) tick();
        bus.data_req_valid = 1'b0;
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h8000;
        repeat (3) tick();
        bus.arready = 1'b0;
        tick();
        bus.inst_req_valid = 1'b0;
        #1;
        chk("t037_in_issue", bus.arvalid, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk("t037_arvalid_async", bus.arvalid, 1'b0);
        chk("t037_araddr_rst", bus.araddr, 32'h0);
        chk("t037_arid_rst", bus.arid, 4'd0);
        chk("t037_arlen_rst", bus.arlen, 4'd0);
        idle_inputs();
        r_q.delete();
        cur_active = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_i = 1'b1; exp_d = 1'b0;
`else
        exp_i = 1'b0; exp_d = 1'b1;
`endif
        bus.inst_req_valid = 1'b1; bus.data_req_valid = 1'b1; bus.arready = 1'b1;
        #1;
        chk("t037_first_inst", bus.inst_req_ready, exp_i);
        chk("t037_first_data", bus.data_req_ready, exp_d);
        repeat (20) tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            rdy = bus.rid[0] ? bus.data_resp_ready : bus.inst_resp_ready;
            if (bus.rvalid && rdy) begin
                if (cur_beat == cur_len) cur_active = 1'b0;
                else cur_beat++;
                bus.rvalid = 1'b0;
            end
            if (!bus.rvalid) begin
                bus.rid = 4'($urandom);
                if (!cur_active && ($urandom_range(1, 0) == 1) &&
                    (pend_i.size() != 0 || pend_d.size() != 0)) begin
                    if (pend_i.size() == 0) cur_side = 1'b1;
                    else if (pend_d.size() == 0) cur_side = 1'b0;
                    else cur_side = 1'($urandom_range(1, 0));
                    cur_len    = cur_side ? pend_d.pop_front() : pend_i.pop_front();
                    cur_beat   = 0;
                    cur_active = 1'b1;
                end
                if (cur_active && ($urandom_range(3, 0) != 0))
                    drive_beat(cur_side, $urandom, cur_beat == cur_len);
            end
            bus.inst_resp_ready = ($urandom_range(9, 0) < 7);
            bus.data_resp_ready = ($urandom_range(9, 0) < 7);
            bus.inst_req_valid  = ($urandom_range(9, 0) < 6);
            bus.data_req_valid  = ($urandom_range(9, 0) < 6);
            bus.inst_req_addr   = $urandom;
            bus.data_req_addr   = $urandom;
            bus.inst_req_len    = 4'($urandom);
            bus.data_req_len    = 4'($urandom);
            bus.arready         = 1'($urandom_range(1, 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
